rob_cmt_sched: RTL and testbench

Commit scheduler for the reorder buffer. Each cycle it inspects the `1<<CONFIG_P_COMMIT_WIDTH` head slots presented by the ROB and decides how many retire in order, returned to the ROB as `cmt_pop_size`. It also sequences the store-buffer commit handshake, and runs the flush/redirect sequence when a retiring entry carries the flush tag.

---
 rtl/rob_cmt_sched_pkg.sv | 12 +
 rtl/cmt_window_calc.sv | 42 ++++
 rtl/rob_cmt_sched.sv | 117 +++++++++++
 tb/tb_rob_cmt_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rob_cmt_sched_pkg.sv
// rtl/rob_cmt_sched_pkg.sv - shared state encoding and widths for the commit scheduler
package rob_cmt_sched_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DRAIN = 2'd2
   } cmt_state_e;

   localparam int DRAIN_CNT_W = 4;

endpackage

// File: rtl/cmt_window_calc.sv
// rtl/cmt_window_calc.sv - combinational retire window: length and first store position
module cmt_window_calc #(
   parameter int P = 1,
   localparam int CW = 1 << P,
   localparam int LW = P + 1,
   localparam int IW = (P > 0) ? P : 1
) (
   input  logic [CW-1:0] i_valid,
   input  logic [CW-1:0] i_fls,
   input  logic [CW-1:0] i_store,
   output logic [LW-1:0] o_len,
   output logic [IW-1:0] o_store_idx,
   output logic          o_store_found
);

   logic w_stop;

   // Window closes at the first invalid slot, before a second store, or just after a flush slot.
   always_comb begin
      o_len         = '0;
      o_store_idx   = '0;
      o_store_found = 1'b0;
      w_stop        = 1'b0;
      for (int i = 0; i < CW; i++) begin
         if (!w_stop) begin
            if (!i_valid[i] || (i_store[i] && o_store_found)) begin
               w_stop = 1'b1;
            end else begin
               if (i_store[i]) begin
                  o_store_found = 1'b1;
                  o_store_idx   = IW'(i);
               end
               o_len = LW'(i + 1);
               if (i_fls[i]) begin
                  w_stop = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/rob_cmt_sched.sv
// rtl/rob_cmt_sched.sv - ROB commit scheduler: in-order retire, store handshake, flush/drain sequencing
module rob_cmt_sched
   import rob_cmt_sched_pkg::*;
#(
   parameter int CONFIG_P_COMMIT_WIDTH = 1,
   parameter int CONFIG_PC_W           = 30,
   parameter int CONFIG_DRAIN_CYCLES   = 2,
   localparam int CW = 1 << CONFIG_P_COMMIT_WIDTH,
   localparam int LW = CONFIG_P_COMMIT_WIDTH + 1,
   localparam int IW = (CONFIG_P_COMMIT_WIDTH > 0) ? CONFIG_P_COMMIT_WIDTH : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CW-1:0]             cmt_valid,
   input  logic [CW-1:0]             cmt_fls,
   input  logic [CW-1:0]             cmt_is_store,
   input  logic [CONFIG_PC_W*CW-1:0] cmt_fls_tgt,
   input  logic                      halt,
   output logic                      stb_req,
   input  logic                      stb_ack,
   output logic [LW-1:0]             cmt_pop_size,
   output logic                      flush,
   output logic [CONFIG_PC_W-1:0]    flush_tgt,
   output logic [31:0]               retire_cnt
);

   cmt_state_e             r_state;
   cmt_state_e             w_next;
   logic [DRAIN_CNT_W-1:0] r_drain;
   logic [DRAIN_CNT_W-1:0] w_drain_nxt;
   logic [CONFIG_PC_W-1:0] r_tgt;
   logic [31:0]            r_cnt;

   logic [LW-1:0]          w_len;
   logic [IW-1:0]          w_st_idx;
   logic                   w_st_found;
   logic [LW-1:0]          w_pop;
   logic [IW-1:0]          w_last;
   logic                   w_fls_pop;
   logic [CONFIG_PC_W-1:0] w_tgt_sel;

   cmt_window_calc #(
      .P (CONFIG_P_COMMIT_WIDTH)
   ) u_window (
      .i_valid       (cmt_valid),
      .i_fls         (cmt_fls),
      .i_store       (cmt_is_store),
      .o_len         (w_len),
      .o_store_idx   (w_st_idx),
      .o_store_found (w_st_found)
   );

   always_comb begin
      w_next      = r_state;
      w_drain_nxt = r_drain;
      w_pop       = '0;
      w_last      = '0;
      w_fls_pop   = 1'b0;
      w_tgt_sel   = '0;
      stb_req     = 1'b0;
      flush       = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (!halt) begin
               if (w_st_found) begin
                  stb_req = 1'b1;
                  w_pop   = stb_ack ? w_len : LW'(w_st_idx);
               end else begin
                  w_pop = w_len;
               end
               // A flush slot can only be the last slot of the window, so check the last popped one.
               w_last    = IW'(w_pop - LW'(1));
               w_tgt_sel = cmt_fls_tgt[w_last*CONFIG_PC_W +: CONFIG_PC_W];
               if ((w_pop != '0) && cmt_fls[w_last]) begin
                  w_fls_pop = 1'b1;
                  w_next    = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            flush       = 1'b1;
            w_drain_nxt = DRAIN_CNT_W'(CONFIG_DRAIN_CYCLES);
            w_next      = ST_DRAIN;
         end
         ST_DRAIN: begin
            w_drain_nxt = r_drain - DRAIN_CNT_W'(1);
            if (r_drain <= DRAIN_CNT_W'(1)) begin
               w_next = ST_RUN;
            end
         end
         default: begin
            w_next = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_drain <= '0;
         r_tgt   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_drain <= w_drain_nxt;
         if (w_fls_pop) begin
            r_tgt <= w_tgt_sel;
         end
         r_cnt <= r_cnt + 32'(w_pop);
      end
   end

   assign cmt_pop_size = w_pop;
   assign flush_tgt    = r_tgt;
   assign retire_cnt   = r_cnt;

endmodule

// File: tb/tb_rob_cmt_sched.sv
// tb/tb_rob_cmt_sched.sv - self-checking bench for rob_cmt_sched (CW=2, DRAIN=2)
module tb_rob_cmt_sched;

   localparam int DRAIN = 2;
   localparam int PCW   = 30;

   logic           clk;
   logic           rst;
   logic [1:0]     cmt_valid;
   logic [1:0]     cmt_fls;
   logic [1:0]     cmt_is_store;
   logic [2*PCW-1:0] cmt_fls_tgt;
   logic           halt;
   logic           stb_req;
   logic           stb_ack;
   logic [1:0]     cmt_pop_size;
   logic           flush;
   logic [PCW-1:0] flush_tgt;
   logic [31:0]    retire_cnt;

   int errors = 0;
   int checks = 0;

   int          m_block;
   logic [31:0] m_cnt;
   logic [PCW-1:0] m_tgt;

   rob_cmt_sched #(
      .CONFIG_P_COMMIT_WIDTH (1),
      .CONFIG_PC_W           (PCW),
      .CONFIG_DRAIN_CYCLES   (DRAIN)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmt_valid    (cmt_valid),
      .cmt_fls      (cmt_fls),
      .cmt_is_store (cmt_is_store),
      .cmt_fls_tgt  (cmt_fls_tgt),
      .halt         (halt),
      .stb_req      (stb_req),
      .stb_ack      (stb_ack),
      .cmt_pop_size (cmt_pop_size),
      .flush        (flush),
      .flush_tgt    (flush_tgt),
      .retire_cnt   (retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, compare against the reference, then advance the reference past the edge.
   task automatic step(input logic [1:0] v, input logic [1:0] f, input logic [1:0] s,
                       input logic [PCW-1:0] t0, input logic [PCW-1:0] t1,
                       input logic h, input logic a);
      int len;
      int k;
      int pop;
      bit done;
      bit stb;
      bit fl_exp;
      cmt_valid    = v;
      cmt_fls      = f;
      cmt_is_store = s;
      cmt_fls_tgt  = {t1, t0};
      halt         = h;
      stb_ack      = a;
      #1;
      len  = 0;
      k    = -1;
      done = 0;
      for (int i = 0; i < 2; i++) begin
         if (!done) begin
            if (!v[i] || (s[i] && k >= 0)) begin
               done = 1;
            end else begin
               if (s[i]) k = i;
               len = i + 1;
               if (f[i]) done = 1;
            end
         end
      end
      fl_exp = (m_block == DRAIN + 1);
      if (m_block > 0 || h) begin
         pop = 0;
         stb = 0;
      end else if (k >= 0) begin
         stb = 1;
         pop = a ? len : k;
      end else begin
         stb = 0;
         pop = len;
      end
      chk("pop", 64'(cmt_pop_size), 64'(pop));
      chk("stb_req", 64'(stb_req), 64'(stb));
      chk("flush", 64'(flush), 64'(fl_exp));
      chk("flush_tgt", 64'(flush_tgt), 64'(m_tgt));
      chk("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
      if (m_block > 0) begin
         m_block--;
      end else if (pop > 0 && f[pop-1]) begin
         m_tgt   = (pop == 1) ? t0 : t1;
         m_block = DRAIN + 1;
      end
      m_cnt = m_cnt + 32'(pop);
      @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      cmt_valid    = '0;
      cmt_fls      = '0;
      cmt_is_store = '0;
      cmt_fls_tgt  = '0;
      halt         = 1'b0;
      stb_ack      = 1'b0;
      m_block      = 0;
      m_cnt        = '0;
      m_tgt        = '0;
      #12;
      chk("rst_pop", 64'(cmt_pop_size), 64'd0);
      chk("rst_stb", 64'(stb_req), 64'd0);
      chk("rst_flush", 64'(flush), 64'd0);
      chk("rst_tgt", 64'(flush_tgt), 64'd0);
      chk("rst_cnt", 64'(retire_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // basic pop and valid gaps
      step(2'b11, 2'b00, 2'b00, 30'h0, 30'h0, 1'b0, 1'b0);
      step(2'b11, 2'b00, 2'b00, 30'h0, 30'h0, 1'b0, 1'b0);
      step(2'b11, 2'b00, 2'b00, 30'h0, 30'h0, 1'b0, 1'b0);
      step(2'b10, 2'b00, 2'b00, 30'h0, 30'h0, 1'b0, 1'b0);
      step(2'b01, 2'b00, 2'b00, 30'h0, 30'h0, 1'b0, 1'b0);
      // store handshake, two stores, ack ignored without a request
      step(2'b11, 2'b00, 2'b10, 30'h0, 30'h0, 1'b0, 1'b0);
      step(2'b11, 2'b00, 2'b10, 30'h0, 30'h0, 1'b0, 1'b1);
      step(2'b11, 2'b00, 2'b11, 30'h0, 30'h0, 1'b0, 1'b1);
      step(2'b11, 2'b00, 2'b11, 30'h0, 30'h0, 1'b0, 1'b1);
      step(2'b11, 2'b00, 2'b00, 30'h0, 30'h0, 1'b0, 1'b1);
      // flush from slot 0, halt during drain has no effect
      step(2'b11, 2'b01, 2'b00, 30'h100, 30'h55, 1'b0, 1'b0);
      step(2'b11, 2'b00, 2'b00, 30'h0, 30'h0, 1'b0, 1'b0);
      step(2'b11, 2'b00, 2'b00, 30'h0, 30'h0, 1'b1, 1'b0);
      step(2'b11, 2'b00, 2'b00, 30'h0, 30'h0, 1'b0, 1'b0);
      step(2'b11, 2'b00, 2'b00, 30'h0, 30'h0, 1'b0, 1'b0);
      // store carrying the flush tag must be acked first
      step(2'b11, 2'b01, 2'b01, 30'h2AB, 30'h1, 1'b0, 1'b0);
      step(2'b11, 2'b01, 2'b01, 30'h2AB, 30'h1, 1'b0, 1'b1);
      repeat (3) step(2'b11, 2'b00, 2'b00, 30'h0, 30'h0, 1'b0, 1'b0);
      // halt in the same cycle as a flush pop wins, then flush from slot 1
      step(2'b11, 2'b10, 2'b00, 30'h7, 30'h3FF0, 1'b1, 1'b0);
      step(2'b11, 2'b10, 2'b00, 30'h7, 30'h3FF0, 1'b0, 1'b0);
      step(2'b11, 2'b00, 2'b00, 30'h0, 30'h0, 1'b0, 1'b0);
      step(2'b11, 2'b00, 2'b00, 30'h0, 30'h0, 1'b0, 1'b0);

      // asynchronous reset while draining
      cmt_valid    = 2'b11;
      cmt_fls      = 2'b00;
      cmt_is_store = 2'b00;
      halt         = 1'b0;
      rst          = 1'b1;
      #1;
      chk("rst_drain_flush", 64'(flush), 64'd0);
      chk("rst_drain_cnt", 64'(retire_cnt), 64'd0);
      chk("rst_drain_tgt", 64'(flush_tgt), 64'd0);
      chk("rst_drain_pop", 64'(cmt_pop_size), 64'd2);
      @(negedge clk);
      rst     = 1'b0;
      m_block = 0;
      m_cnt   = '0;
      m_tgt   = '0;

      step(2'b11, 2'b00, 2'b10, 30'h0, 30'h0, 1'b1, 1'b1);
      step(2'b11, 2'b00, 2'b00, 30'h0, 30'h0, 1'b0, 1'b0);

      for (int n = 0; n < 400; n++) begin
         step(2'($urandom),
              {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)},
              2'($urandom),
              30'($urandom), 30'($urandom),
              ($urandom_range(0, 7) == 0),
              1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
